// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
package calc_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SETTLE = 2'd2,
    SHOW   = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/calc_sequencer_rise_detect.sv
// Single-bit registered 0->1 edge detector.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  // Remember the previous level every cycle, regardless of what the consumer does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/calc_sequencer.sv
// Operand/operation entry sequencer for the external add/sub datapath.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int n             = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_enter,
  input  logic         btn_clear,
  input  logic [n-1:0] sw_operand,
  input  logic         sw_op,
  output logic [n-1:0] op_a,
  output logic [n-1:0] op_b,
  output logic         sel_sub,
  input  logic [n-1:0] sel_res,
  input  logic         sel_neg,
  output logic [n-1:0] result,
  output logic         result_neg,
  output logic         result_valid,
  output logic [1:0]   state_code,
  output logic         busy
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e       state_q, state_d;
  logic [n-1:0] op_a_q, op_a_d;
  logic [n-1:0] op_b_q, op_b_d;
  logic         sel_sub_q, sel_sub_d;
  logic [n-1:0] result_q, result_d;
  logic         result_neg_q, result_neg_d;
  logic         result_valid_q, result_valid_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         enter_rise;

  rise_detect u_enter_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (btn_enter),
    .rise_o (enter_rise)
  );

  // State and datapath-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LOAD_A;
      op_a_q         <= '0;
      op_b_q         <= '0;
      sel_sub_q      <= 1'b0;
      result_q       <= '0;
      result_neg_q   <= 1'b0;
      result_valid_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      sel_sub_q      <= sel_sub_d;
      result_q       <= result_d;
      result_neg_q   <= result_neg_d;
      result_valid_q <= result_valid_d;
      cnt_q          <= cnt_d;
    end
  end

  // Next-state logic; Clear overrides everything, including a coincident Enter edge.
  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    sel_sub_d      = sel_sub_q;
    result_d       = result_q;
    result_neg_d   = result_neg_q;
    result_valid_d = result_valid_q;
    cnt_d          = cnt_q;

    if (btn_clear) begin
      state_d        = LOAD_A;
      op_a_d         = '0;
      op_b_d         = '0;
      sel_sub_d      = 1'b0;
      result_d       = '0;
      result_neg_d   = 1'b0;
      result_valid_d = 1'b0;
      cnt_d          = '0;
    end else begin
      unique case (state_q)
        LOAD_A: if (enter_rise) begin
          op_a_d    = sw_operand;
          sel_sub_d = (sw_op == OP_SUB);
          state_d   = LOAD_B;
        end
        LOAD_B: if (enter_rise) begin
          op_b_d  = sw_operand;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
        // Enter edges here are deliberately dropped; the detector still tracks the level.
        SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            result_d       = sel_res;
            result_neg_d   = sel_neg;
            result_valid_d = 1'b1;
            state_d        = SHOW;
          end
        end
        SHOW: if (enter_rise) begin
          result_valid_d = 1'b0;
          state_d        = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign sel_sub      = sel_sub_q;
  assign result       = result_q;
  assign result_neg   = result_neg_q;
  assign result_valid = result_valid_q;
  assign state_code   = state_q;
  assign busy         = (state_q == SETTLE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural add/sub/sign-magnitude datapath.
module tb_calc_sequencer;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         btn_enter, btn_clear, sw_op;
  logic [N-1:0] sw_operand;
  logic [N-1:0] op_a, op_b, sel_res, result;
  logic         sel_sub, sel_neg, result_neg, result_valid, busy;
  logic [1:0]   state_code;

  int errs = 0;
  int checks = 0;

  calc_sequencer #(.n(N), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .sw_operand(sw_operand), .sw_op(sw_op), .op_a(op_a), .op_b(op_b),
    .sel_sub(sel_sub), .sel_res(sel_res), .sel_neg(sel_neg), .result(result),
    .result_neg(result_neg), .result_valid(result_valid),
    .state_code(state_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // External datapath model: adder/subtractor then sign/magnitude selector.
  logic [N-1:0] dp_raw;
  always_comb begin
    dp_raw  = sel_sub ? (op_a - op_b) : (op_a + op_b);
    sel_neg = dp_raw[N-1];
    sel_res = dp_raw[N-1] ? (~dp_raw + 1'b1) : dp_raw;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean Enter press: edge sampled on the first tick, released on the second.
  task automatic press(input logic [N-1:0] val, input logic op);
    sw_operand = val;
    sw_op      = op;
    btn_enter  = 1'b1;
    tick();
    btn_enter  = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0; sw_op = 1'b0; sw_operand = '0;
    #23 rst_n = 1'b1;
    tick();
    chk("rst_state", state_code, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);

    // 5 + 3
    press(6'd5, 1'b0);
    chk("add_state_b", state_code, 1);
    chk("add_op_a", op_a, 5);
    chk("add_sel_sub", sel_sub, 0);
    sw_operand = 6'd3; btn_enter = 1'b1; tick(); btn_enter = 1'b0;   // B sampled here
    chk("add_op_b", op_b, 3);
    chk("add_busy0", busy, 1);
    tick();
    chk("add_valid_early", result_valid, 0);
    tick();
    chk("add_valid", result_valid, 1);
    chk("add_result", result, 8);
    chk("add_neg", result_neg, 0);
    chk("add_state_show", state_code, 3);
    sw_operand = 6'd17; tick();
    chk("show_hold", result, 8);

    // Back to LOAD_A, then 3 - 5
    press(6'd0, 1'b0);
    chk("show_exit_state", state_code, 0);
    chk("show_exit_valid", result_valid, 0);
    press(6'd3, 1'b1);
    chk("sub_sel_sub", sel_sub, 1);
    sw_operand = 6'd5; btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    chk("sub_busy1", busy, 1);
    tick();
    chk("sub_busy2", busy, 1);
    tick();
    chk("sub_busy_off", busy, 0);
    chk("sub_valid", result_valid, 1);
    chk("sub_result", result, 2);
    chk("sub_neg", result_neg, 1);

    // Held Enter in LOAD_A gives one action; Enter edge in SETTLE is ignored.
    press(6'd0, 1'b0);
    sw_operand = 6'd10; sw_op = 1'b0; btn_enter = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("held_state", state_code, 1);
    chk("held_op_a", op_a, 10);
    btn_enter = 1'b0; tick();
    sw_operand = 6'd4; btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    chk("settle_enter_s", state_code, 2);
    tick();
    btn_enter = 1'b1; tick();                 // edge lands on the latching cycle
    chk("settle_edge_show", state_code, 3);
    chk("settle_edge_res", result, 14);
    tick();
    chk("settle_edge_hold", state_code, 3);
    btn_enter = 1'b0; tick();

    // Clear in LOAD_B
    press(6'd0, 1'b0);
    press(6'd7, 1'b1);
    chk("clr_pre_op_a", op_a, 7);
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    chk("clr_state", state_code, 0);
    chk("clr_op_a", op_a, 0);
    chk("clr_sel_sub", sel_sub, 0);
    chk("clr_valid", result_valid, 0);
    // Clear and Enter edge together
    sw_operand = 6'd9; btn_clear = 1'b1; btn_enter = 1'b1; tick();
    btn_clear = 1'b0; tick();
    chk("clr_ent_state", state_code, 0);
    chk("clr_ent_op_a", op_a, 0);
    btn_enter = 1'b0; tick();

    // Async reset in SETTLE
    press(6'd1, 1'b0);
    sw_operand = 6'd1; btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    chk("rst2_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_state", state_code, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_op_a", op_a, 0);
    chk("rst2_op_b", op_b, 0);
    #3 rst_n = 1'b1;
    tick();

    // 31 + 1 overflows to 100000: selector reports magnitude 32, negative
    press(6'd31, 1'b0);
    press(6'd1, 1'b0);
    tick();
    chk("ovf_valid", result_valid, 1);
    chk("ovf_result", result, 32);
    chk("ovf_neg", result_neg, 1);
    press(6'd0, 1'b0);
    chk("ovf_exit_valid", result_valid, 0);
    chk("ovf_exit_state", state_code, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
